// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: opcodes, error codes,
// FSM states and the default WAIT timeout.
package calc_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 32;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DIVQ = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVR = 3'b100;
  localparam logic [2:0] OP_SQRT = 3'b101;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/calc_sequencer.sv
// Front-end sequencer for a small calculator: ADD/SUB are computed inline,
// MUL/DIV/SQRT are handed to an external shared iterative unit with a timeout.
//
// state  | meaning
// IDLE   | ready for a request; accept edge latches the operation
// LAUNCH | one-cycle unit_start pulse, timeout counter cleared
// WAIT   | waiting for unit_done or timeout
// FINISH | one-cycle done pulse, op_count advances
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] opcode,
  input  logic [7:0] operands,
  output logic       unit_start,
  output logic [2:0] unit_op,
  output logic [7:0] unit_operands,
  input  logic       unit_done,
  input  logic [7:0] unit_result,
  output logic [7:0] result,
  output logic       done,
  output logic [1:0] err,
  output logic [7:0] op_count
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [7:0]        result_nxt;
  logic [1:0]        err_nxt;
  logic [2:0]        unit_op_nxt;
  logic [7:0]        unit_operands_nxt;
  logic [7:0]        op_count_nxt;
  logic [3:0]        opnd_a, opnd_b;

  assign opnd_a = operands[7:4];
  assign opnd_b = operands[3:0];

  assign op_ready   = (state == ST_IDLE);
  assign unit_start = (state == ST_LAUNCH);
  assign done       = (state == ST_FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      result        <= 8'h00;
      err           <= ERR_NONE;
      unit_op       <= 3'b000;
      unit_operands <= 8'h00;
      op_count      <= 8'h00;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      result        <= result_nxt;
      err           <= err_nxt;
      unit_op       <= unit_op_nxt;
      unit_operands <= unit_operands_nxt;
      op_count      <= op_count_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    result_nxt        = result;
    err_nxt           = err;
    unit_op_nxt       = unit_op;
    unit_operands_nxt = unit_operands;
    op_count_nxt      = op_count;

    case (state)
      ST_IDLE: begin
        if (op_valid) begin
          unit_op_nxt       = opcode;
          unit_operands_nxt = operands;
          err_nxt           = ERR_NONE;
          state_nxt         = ST_FINISH;
          case (opcode)
            OP_ADD: result_nxt = {3'b000, {1'b0, opnd_a} + {1'b0, opnd_b}};
            OP_SUB: result_nxt = {4'h0, opnd_a} - {4'h0, opnd_b};
            OP_DIVQ, OP_DIVR: begin
              // Divide by zero is caught here so the unit is never launched.
              if (opnd_b == 4'h0) begin
                err_nxt    = ERR_DIV0;
                result_nxt = 8'h00;
              end else begin
                state_nxt = ST_LAUNCH;
              end
            end
            OP_MUL, OP_SQRT: state_nxt = ST_LAUNCH;
            default: begin
              err_nxt    = ERR_ILLEGAL;
              result_nxt = 8'h00;
            end
          endcase
        end
      end

      ST_LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        // unit_done takes priority over a timeout landing on the same edge.
        if (unit_done) begin
          result_nxt = unit_result;
          state_nxt  = ST_FINISH;
        end else if (cnt == CNT_LAST) begin
          err_nxt    = ERR_TIMEOUT;
          result_nxt = 8'h00;
          state_nxt  = ST_FINISH;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_FINISH: begin
        op_count_nxt = op_count + 8'd1;
        state_nxt    = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: table of single-cycle ops, then
// hand-written unit handshakes, timeout, reset-abandon and op_count wrap.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [7:0] operands = 8'h00;
  logic       unit_done = 1'b0;
  logic [7:0] unit_result = 8'h00;
  logic       op_ready, unit_start, done;
  logic [2:0] unit_op;
  logic [7:0] unit_operands, result, op_count;
  logic [1:0] err;

  calc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .operands(operands), .unit_start(unit_start),
    .unit_op(unit_op), .unit_operands(unit_operands), .unit_done(unit_done),
    .unit_result(unit_result), .result(result), .done(done), .err(err),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int starts = 0;

  always @(negedge clk) if (rst_n && unit_start) starts++;

  typedef struct packed {
    logic [2:0] opc;
    logic [7:0] opnds;
    logic [7:0] res;
    logic [1:0] err;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic accept(input logic [2:0] opc, input logic [7:0] opnds);
    int guard = 0;
    while (!op_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_accept", op_ready, 1);
    opcode   = opc;
    operands = opnds;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic do_simple(input int idx, input vec_t v);
    int         s0 = starts;
    logic [7:0] cnt_exp;
    cnt_exp = op_count + 8'd1;
    accept(v.opc, v.opnds);
    check($sformatf("v%0d_done", idx), done, 1);
    check($sformatf("v%0d_ready_low", idx), op_ready, 0);
    check($sformatf("v%0d_result", idx), result, v.res);
    check($sformatf("v%0d_err", idx), err, v.err);
    @(posedge clk); #1;
    check($sformatf("v%0d_done_single", idx), done, 0);
    check($sformatf("v%0d_ready_back", idx), op_ready, 1);
    check($sformatf("v%0d_op_count", idx), op_count, cnt_exp);
    check($sformatf("v%0d_no_start", idx), starts, s0);
  endtask

  // done_at: WAIT cycle (1-based) in which unit_done is driven, 0 = never.
  task automatic do_unit(input string nm, input logic [2:0] opc, input logic [7:0] opnds,
                         input int done_at, input logic [7:0] urs,
                         input logic [7:0] exp_res, input logic [1:0] exp_err,
                         input logic poke);
    int         s0 = starts;
    int         seen = 0;
    int         exp_k;
    logic       stable = 1'b1;
    logic [7:0] cnt_exp;
    cnt_exp = op_count + 8'd1;
    exp_k = (done_at >= 1 && done_at <= 32) ? done_at : 32;
    accept(opc, opnds);
    check({nm, "_launch_start"}, unit_start, 1);
    check({nm, "_launch_nodone"}, done, 0);
    check({nm, "_launch_err_clr"}, err, ERR_NONE);
    check({nm, "_unit_op"}, unit_op, opc);
    check({nm, "_unit_operands"}, unit_operands, opnds);
    @(posedge clk); #1;
    check({nm, "_start_single"}, unit_start, 0);
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      if (k == done_at) begin
        unit_done   = 1'b1;
        unit_result = urs;
      end
      if (poke && k == 2) begin
        op_valid = 1'b1;
        opcode   = OP_ADD;
        operands = 8'h11;
      end
      @(posedge clk); #1;
      unit_done = 1'b0;
      op_valid  = 1'b0;
      if (done) seen = k;
      else if (unit_op !== opc || unit_operands !== opnds || unit_start) stable = 1'b0;
    end
    check({nm, "_done_cycle"}, seen, exp_k);
    check({nm, "_result"}, result, exp_res);
    check({nm, "_err"}, err, exp_err);
    check({nm, "_wait_stable"}, stable, 1);
    check({nm, "_one_start"}, starts, s0 + 1);
    @(posedge clk); #1;
    check({nm, "_op_count"}, op_count, cnt_exp);
    check({nm, "_idle_nodone"}, done, 0);
    @(posedge clk); #1;
    check({nm, "_not_queued"}, op_ready, 1);
    check({nm, "_result_held"}, result, exp_res);
  endtask

  initial begin
    vecs[0]  = '{OP_ADD,  8'h98, 8'h11, ERR_NONE};
    vecs[1]  = '{OP_ADD,  8'hFF, 8'h1E, ERR_NONE};
    vecs[2]  = '{OP_ADD,  8'h00, 8'h00, ERR_NONE};
    vecs[3]  = '{OP_SUB,  8'h35, 8'hFE, ERR_NONE};
    vecs[4]  = '{OP_SUB,  8'hF0, 8'h0F, ERR_NONE};
    vecs[5]  = '{OP_SUB,  8'h08, 8'hF8, ERR_NONE};
    vecs[6]  = '{OP_DIVQ, 8'h70, 8'h00, ERR_DIV0};
    vecs[7]  = '{OP_DIVR, 8'hA0, 8'h00, ERR_DIV0};
    vecs[8]  = '{3'b110,  8'h12, 8'h00, ERR_ILLEGAL};
    vecs[9]  = '{3'b111,  8'hFF, 8'h00, ERR_ILLEGAL};
    vecs[10] = '{OP_ADD,  8'h7A, 8'h11, ERR_NONE};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", op_ready, 1);
    check("rst_done", done, 0);
    check("rst_start", unit_start, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_count", op_count, 0);
    check("rst_unit_op", unit_op, 0);
    check("rst_unit_operands", unit_operands, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) do_simple(i, vecs[i]);

    unit_done   = 1'b1;
    unit_result = 8'hA5;
    @(posedge clk); #1;
    unit_done = 1'b0;
    check("idle_stale_done", done, 0);
    check("idle_stale_result", result, 8'h11);
    check("idle_stale_ready", op_ready, 1);

    do_unit("mul",      OP_MUL,  8'h34, 4,  8'h0C, 8'h0C, ERR_NONE, 1'b1);
    do_unit("sqrt_to",  OP_SQRT, 8'h51, 0,  8'h00, 8'h00, ERR_TIMEOUT, 1'b0);
    do_unit("divq_1",   OP_DIVQ, 8'h73, 1,  8'h02, 8'h02, ERR_NONE, 1'b0);
    do_unit("divr_tie", OP_DIVR, 8'h73, 32, 8'h01, 8'h01, ERR_NONE, 1'b0);
    do_unit("sqrt_31",  OP_SQRT, 8'h10, 31, 8'h04, 8'h04, ERR_NONE, 1'b0);

    accept(OP_MUL, 8'h23);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstw_ready", op_ready, 1);
    check("rstw_done", done, 0);
    check("rstw_start", unit_start, 0);
    check("rstw_unit_op", unit_op, 0);
    check("rstw_unit_operands", unit_operands, 0);
    check("rstw_result", result, 0);
    check("rstw_count", op_count, 0);
    @(posedge clk); #1;
    rst_n       = 1'b1;
    unit_done   = 1'b1;
    unit_result = 8'h55;
    @(posedge clk); #1;
    unit_done = 1'b0;
    check("stale_done", done, 0);
    check("stale_result", result, 0);
    check("stale_err", err, 0);
    @(posedge clk); #1;
    check("stale_done2", done, 0);
    check("stale_count", op_count, 0);
    check("stale_ready", op_ready, 1);

    begin
      logic ok = 1'b1;
      for (int n = 1; n <= 256; n++) begin
        opcode   = OP_ADD;
        operands = 8'h11;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        if (!done) ok = 1'b0;
        @(posedge clk); #1;
        if (n == 255) check("count_255", op_count, 8'd255);
      end
      check("wrap_done_each", ok, 1);
      check("count_wrap", op_count, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end

endmodule
